// File: rtl/code_sched.sv
// code_sched: sequencing controller for the two-channel code datapath.
// Grants one of two job requests, drives the datapath Slt/En for the job
// length, then captures the selected datapath output as the job result.
// Optional feature macro: CODE_SCHED_RR_EN selects round-robin tie-breaking;
// when it is undefined, channel 0 has fixed priority on a tie.
module code_sched #(
  parameter int CNT_W  = 8,
  parameter int DATA_W = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0,
  input  logic [CNT_W-1:0]  Cnt0,
  input  logic              Req1,
  input  logic [CNT_W-1:0]  Cnt1,
  output logic              Ack0,
  output logic              Ack1,
  output logic              Slt,
  output logic              En,
  input  logic [DATA_W-1:0] Output0,
  input  logic [DATA_W-1:0] Output1,
  output logic              Busy,
  output logic              Done,
  output logic              DoneCh,
  output logic [DATA_W-1:0] Result
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CAPT
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                slt_q, slt_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                done_q, done_d;
  logic                doneCh_q, doneCh_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                winner;
  logic [CNT_W-1:0]    winCnt;
`ifdef CODE_SCHED_RR_EN
  logic                lastServed_q, lastServed_d;
`endif

  // State register plus all registered outputs; reset aborts any job in flight
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      slt_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      done_q   <= 1'b0;
      doneCh_q <= 1'b0;
      result_q <= '0;
`ifdef CODE_SCHED_RR_EN
      lastServed_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      slt_q    <= slt_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      done_q   <= done_d;
      doneCh_q <= doneCh_d;
      result_q <= result_d;
`ifdef CODE_SCHED_RR_EN
      lastServed_q <= lastServed_d;
`endif
    end
  end

  // Arbitration, next-state and next-output logic; pulses default low each cycle
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    slt_d    = slt_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    done_d   = 1'b0;
    doneCh_d = doneCh_q;
    result_d = result_q;
`ifdef CODE_SCHED_RR_EN
    lastServed_d = lastServed_q;
    winner       = (Req0 && Req1) ? ~lastServed_q : Req1;
`else
    winner       = ~Req0;
`endif
    winCnt = winner ? Cnt1 : Cnt0;

    case (state_q)
      IDLE: begin
        if (Req0 || Req1) begin
          slt_d  = winner;
          ack0_d = ~winner;
          ack1_d = winner;
          rem_d  = winCnt;
          state_d = (winCnt != '0) ? RUN : CAPT;
`ifdef CODE_SCHED_RR_EN
          lastServed_d = winner;
`endif
        end
      end
      RUN: begin
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        result_d = slt_q ? Output1 : Output0;
        doneCh_d = slt_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign En     = (state_q == RUN);
  assign Busy   = (state_q != IDLE);
  assign Slt    = slt_q;
  assign Ack0   = ack0_q;
  assign Ack1   = ack1_q;
  assign Done   = done_q;
  assign DoneCh = doneCh_q;
  assign Result = result_q;

endmodule
